// File: rtl/pill_dispenser.sv
// rtl/pill_dispenser.sv - pill-drop sequencer: paced pill pulses per bottle quota, running total.
module pill_dispenser #(
  parameter int GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pillc,
  input  logic       start,
  input  logic       bottle_rdy,
  output logic       pill,
  output logic       bottle_done,
  output logic       busy,
  output logic       fault,
  output logic [9:0] total
);

  typedef enum logic [2:0] {
    S_IDLE, S_DROP, S_GAP, S_DONE, S_WAITRM, S_FAULT
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_rst_sync;
  logic [5:0] r_remaining;
  logic [3:0] r_gap_cnt;
  logic [9:0] r_total;
  logic       r_pill, r_bottle_done, r_busy, r_fault;
  logic       w_pill_nxt, w_done_nxt, w_busy_nxt, w_fault_nxt;

  // Release flop; together with the state register this gives the two-flop release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 1'b0;
    else      r_rst_sync <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_state <= S_IDLE;
    else if (!r_rst_sync) r_state <= S_IDLE;
    else                  r_state <= w_next;
  end

  // Bottle loss outranks pause, which outranks normal advance.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start && bottle_rdy && (pillc != 6'd0)) w_next = S_DROP;
      S_DROP: begin
        if (!bottle_rdy)               w_next = S_FAULT;
        else if (r_remaining == 6'd1)  w_next = S_DONE;
        else                           w_next = S_GAP;
      end
      S_GAP: begin
        if (!bottle_rdy)                        w_next = S_FAULT;
        else if (start && (r_gap_cnt == 4'd0))  w_next = S_DROP;
      end
      S_DONE:   w_next = S_WAITRM;
      S_WAITRM: if (!bottle_rdy) w_next = S_IDLE;
      S_FAULT:  if (!start)      w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pill_nxt  = (w_next == S_DROP);
    w_done_nxt  = (w_next == S_DONE);
    w_busy_nxt  = (w_next == S_DROP) || (w_next == S_GAP) || (w_next == S_DONE);
    w_fault_nxt = (w_next == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining <= 6'd0;
      r_gap_cnt   <= 4'd0;
      r_total     <= 10'd0;
    end else if (!r_rst_sync) begin
      r_remaining <= 6'd0;
      r_gap_cnt   <= 4'd0;
      r_total     <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_next == S_DROP) r_remaining <= pillc;
        S_DROP: begin
          r_remaining <= r_remaining - 6'd1;
          r_total     <= r_total + 10'd1;
          r_gap_cnt   <= GAP_LOAD;
        end
        S_GAP: if (bottle_rdy && start && (r_gap_cnt != 4'd0)) r_gap_cnt <= r_gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pill        <= 1'b0;
      r_bottle_done <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
    end else if (!r_rst_sync) begin
      r_pill        <= 1'b0;
      r_bottle_done <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_pill        <= w_pill_nxt;
      r_bottle_done <= w_done_nxt;
      r_busy        <= w_busy_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  assign pill        = r_pill;
  assign bottle_done = r_bottle_done;
  assign busy        = r_busy;
  assign fault       = r_fault;
  assign total       = r_total;

endmodule

// File: tb/tb_pill_dispenser.sv
// tb/tb_pill_dispenser.sv - scoreboard bench for pill_dispenser.
module tb_pill_dispenser;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pillc;
  logic       start;
  logic       bottle_rdy;
  logic       pill;
  logic       bottle_done;
  logic       busy;
  logic       fault;
  logic [9:0] total;

  pill_dispenser #(.GAP(GAP)) dut (
    .clk(clk), .rst(rst), .pillc(pillc), .start(start), .bottle_rdy(bottle_rdy),
    .pill(pill), .bottle_done(bottle_done), .busy(busy), .fault(fault), .total(total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] tot;
  } exp_t;

  exp_t       pill_q[$];
  int         done_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [9:0] exp_total = 10'd0;
  int         k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pill) begin
        if (pill_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL pill_unexpected: got pill=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = pill_q.pop_front();
          chk("pill_cycle", cyc, e.cyc);
          chk("pill_total", int'(total), int'(e.tot));
        end
      end
      if (bottle_done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL done_unexpected: got bottle_done=1 expected none (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic push_pill(input int c);
    exp_t e;
    e.cyc = c;
    e.tot = exp_total;
    pill_q.push_back(e);
    exp_total = exp_total + 10'd1;
  endtask

  task automatic run_bottle(input int n, input int hold);
    int kk;
    @(negedge clk);
    pillc = 6'(n); start = 1'b1; bottle_rdy = 1'b1;
    kk = cyc + 1;
    for (int i = 0; i < n; i++) push_pill(kk + i * (GAP + 1));
    done_q.push_back(kk + (n - 1) * (GAP + 1) + 1);
    repeat ((n - 1) * (GAP + 1) + 3 + hold) @(negedge clk);
    chk("pills_missing", pill_q.size(), 0);
    chk("done_missing", done_q.size(), 0);
    chk("busy_waitrm", busy, 0);
    bottle_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; pillc = 6'd0; start = 1'b0; bottle_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pill", pill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_total", total, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic fill, then bottle stays ready: no refill
    run_bottle(3, 10);
    chk("basic_total", total, int'(exp_total));

    // Pause of 7 cycles after the second pill, pillc changed mid-fill
    @(negedge clk);
    pillc = 6'd5; start = 1'b1; bottle_rdy = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 5; i++) push_pill(k + i * (GAP + 1) + ((i >= 2) ? 7 : 0));
    done_q.push_back(k + 4 * (GAP + 1) + 7 + 1);
    repeat (7) @(negedge clk);
    start = 1'b0; pillc = 6'd1;
    repeat (7) @(negedge clk);
    start = 1'b1;
    repeat (16) @(negedge clk);
    chk("pause_pills_missing", pill_q.size(), 0);
    chk("pause_done_missing", done_q.size(), 0);
    chk("pause_total", total, 8);
    chk("pause_fault", fault, 0);
    bottle_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Zero quota
    @(negedge clk);
    pillc = 6'd0; start = 1'b1; bottle_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("zero_busy", busy, 0);
    end
    chk("zero_total", total, 8);
    bottle_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Bottle loss after second pill
    @(negedge clk);
    pillc = 6'd6; start = 1'b1; bottle_rdy = 1'b1;
    k = cyc + 1;
    push_pill(k);
    push_pill(k + GAP + 1);
    repeat (7) @(negedge clk);
    bottle_rdy = 1'b0;
    @(negedge clk);
    chk("loss_fault", fault, 1);
    chk("loss_busy", busy, 0);
    chk("loss_total", total, 10);
    repeat (10) @(negedge clk);
    chk("loss_fault_sticky", fault, 1);
    chk("loss_no_more_pills", pill_q.size(), 0);
    start = 1'b0;
    @(negedge clk);
    chk("fault_cleared", fault, 0);
    run_bottle(6, 0);
    chk("refill_total", total, 16);

    // Asynchronous reset mid-fill
    @(negedge clk);
    pillc = 6'd6; start = 1'b1; bottle_rdy = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 6; i++) push_pill(k + i * (GAP + 1));
    repeat (8) @(negedge clk);
    chk("midfill_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pill", pill, 0);
    chk("arst_fault", fault, 0);
    chk("arst_total", total, 0);
    pill_q.delete();
    done_q.delete();
    exp_total = 10'd0;
    start = 1'b0; bottle_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_bottle_done", bottle_done, 0);

    // Wrap: 171 bottles of 6 pills
    for (int b = 0; b < 171; b++) run_bottle(6, 0);
    chk("wrap_total", total, 2);
    chk("final_queue", pill_q.size() + done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pill_dispenser.md
# pill_dispenser

Pill-drop sequencer for the bottling line: the source side of the pill-counting path. Once `start` is high and a bottle is in place, it emits one `pill` pulse per dispensed pill, spaced by a fixed gap, until the per-bottle quota `pillc` is met. It then pulses `bottle_done` and waits for the bottle to be removed. It keeps a 10-bit running total that matches the counter's `countp` width.

## Interface

Parameters:
- `GAP`, default 4: idle cycles between consecutive `pill` pulses. Legal range 1–15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pillc`  in  6  pills per bottle. Sampled only on the IDLE→DROP transition.
- `start`  in  1  run enable. High: run. Low: pause, or clear a fault.
- `bottle_rdy`  in  1  conveyor reports a bottle in place under the chute.
- `pill`  out  1  one-cycle pulse per pill dropped.
- `bottle_done`  out  1  one-cycle pulse when the quota is met.
- `busy`  out  1  high in DROP, GAP and DONE.
- `fault`  out  1  sticky; set when a bottle is lost mid-fill.
- `total`  out  10  pills dispensed since reset. Wraps modulo 1024.

## Operation

- Registers: 6-bit `remaining`, 4-bit gap counter, 10-bit `total`, state.
- Every output is registered.
- States: IDLE, DROP, GAP, DONE, WAITRM, FAULT.
- IDLE:
  - Condition to leave: `start` = 1, `bottle_rdy` = 1 and `pillc` ≠ 0.
  - Action on that edge: load `remaining` ← `pillc`; next state DROP.
  - `pillc` = 0: stay in IDLE. No pulses.
- DROP (exactly one cycle):
  - `pill` = 1; `total` ← `total` + 1; `remaining` ← `remaining` − 1.
  - If the post-decrement `remaining` = 0: next state DONE.
  - Otherwise: load the gap counter ← `GAP` − 1; next state GAP.
- GAP:
  - With `start` = 1: decrement the gap counter each cycle. When it is 0 and `start` = 1, next state DROP.
  - With `start` = 0: hold the counter and state (pause). Counting resumes the cycle after `start` returns to 1.
- DONE (one cycle): `bottle_done` = 1; next state WAITRM.
- WAITRM: stay until `bottle_rdy` = 0, then IDLE. This prevents double-filling the same bottle.
- Bottle loss: `bottle_rdy` = 0 while in DROP or GAP.
  - Next state FAULT; `fault` ← 1.
  - The pill already pulsed in that DROP cycle is still counted in `total`.
- FAULT:
  - `fault` stays 1 and `busy` = 0.
  - Exit only when `start` = 0: `fault` ← 0, next state IDLE.
- Priority within a cycle: bottle loss > pause > normal advance.
- `pillc` changes during a fill have no effect on the bottle in progress.
- `total` wraps 1023 → 0 silently.

## Timing

- Reset (`rst` = 0, asynchronous):
  - State IDLE.
  - `pill`, `bottle_done`, `busy`, `fault` = 0.
  - `total` = 0; `remaining` and gap counter = 0.
- Reset deassertion is synchronised inside the block: two-flop release.
- The first clock edge that can leave IDLE is the second rising edge after `rst` goes high.
- Latency:
  - Start condition sampled at edge k: first `pill` high from edge k to edge k+1.
  - Pill spacing is `GAP` + 1 cycles with no pause.
  - `bottle_done` is high the cycle after the last `pill`.
- Fill duration for N pills: N + (N−1)·`GAP` + 1 cycles, from first `pill` to end of `bottle_done`.
- `busy` rises in the same cycle as the first `pill` and falls on entry to WAITRM or FAULT.
- Reset mid-fill: all state is lost immediately and `total` is cleared. There is no partial `bottle_done`.

## Test plan

- Basic fill, `GAP` = 4, `pillc` = 3, `start` = 1, bottle ready at edge k:
  - `pill` at cycles k+1, k+6, k+11.
  - `bottle_done` at k+12.
  - `total` = 3.
  - No further pulses until `bottle_rdy` toggles 0 then 1.
- Pause: `pillc` = 5, drop `start` for 7 cycles after the second pill.
  - Third pill is delayed by exactly 7 cycles.
  - `total` = 5 at the end; `fault` = 0.
- Zero quota: `pillc` = 0 with `start` and bottle ready for 20 cycles.
  - No `pill`, `busy` = 0, `total` unchanged.
- Bottle loss: `pillc` = 6, drop `bottle_rdy` after the 2nd pill.
  - `fault` = 1 next cycle; `total` = 2; no more pills.
  - `start` = 0 clears `fault`.
  - A fresh bottle then gets a full 6 pills.
- Reset and wrap, two parts:
  - Assert `rst` mid-fill: outputs are 0 asynchronously.
  - Run 171 bottles of 6 pills: `total` = 1026 mod 1024 = 2.
